ipd_rr_arbiter: RTL and testbench
=================================

// Module: ipd_rr_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter for the generator. It shares one inter-packet-delay
//  datapath between NUM_PORTS AXI4-Stream packet sources and sits directly upstream of the
//  delay stage's slave stream port. A grant is held for one whole packet (through tlast).
//  Enable, port-mask and soft reset come from the AXI-Lite register bank.
// PARAMETERS
//  C_AXIS_DATA_WIDTH   256  tdata width; tstrb is C_AXIS_DATA_WIDTH/8
//  C_AXIS_TUSER_WIDTH  128  tuser width, passed through unmodified
//  NUM_PORTS           4    number of source streams, legal range 2..8
//  C_CNT_WIDTH         32   width of the granted-packet counter
// PORTS
//  axi_aclk       in   1                       the single clock
//  axi_areset     in   1                       asynchronous, active-high reset
//  sw_rst         in   1                       synchronous soft reset (register bit)
//  arb_en         in   1                       1 = arbitration enabled
//  port_mask      in   NUM_PORTS               bit i = 1 makes source i eligible
//  s_axis_tdata   in   NUM_PORTS*DATA          source i occupies slice i
//  s_axis_tstrb   in   NUM_PORTS*DATA/8        source i occupies slice i
//  s_axis_tuser   in   NUM_PORTS*TUSER         source i occupies slice i
//  s_axis_tvalid  in   NUM_PORTS               per-source valid
//  s_axis_tlast   in   NUM_PORTS               per-source last
//  s_axis_tready  out  NUM_PORTS               per-source ready
//  m_axis_tdata   out  DATA                    to the delay stage
//  m_axis_tstrb   out  DATA/8                  to the delay stage
//  m_axis_tuser   out  TUSER                   to the delay stage
//  m_axis_tvalid  out  1                       to the delay stage
//  m_axis_tlast   out  1                       to the delay stage
//  m_axis_tready  in   1                       from the delay stage
//  cur_port       out  clog2(NUM_PORTS)        index of the granted (or last granted) source
//  pkt_cnt        out  C_CNT_WIDTH             number of packets completed
// BEHAVIOUR
//  FSM states: IDLE, XFER. State register: grant, last_grant, pkt_cnt.
//  Reset (axi_areset=1): state=IDLE, last_grant=NUM_PORTS-1, grant=0, pkt_cnt=0.
//    Outputs during reset: all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, cur_port=0.
//  sw_rst=1 at a clock edge: same register values as reset, applied synchronously.
//    It takes priority over every other event.
//    A packet in progress is abandoned mid-packet; the truncation is accepted by design.
//  IDLE:
//    - req = s_axis_tvalid & port_mask.
//    - If arb_en=1 and req!=0: grant <= first set bit of req, searching from last_grant+1
//      and wrapping modulo NUM_PORTS. Next state is XFER.
//    - Otherwise remain in IDLE.
//    - m_axis_tvalid=0 and all s_axis_tready=0 in IDLE.
//  XFER (output logic is combinational from inputs; zero latency through the block):
//    - m_axis_{tdata,tstrb,tuser,tlast} = slice[grant].
//    - m_axis_tvalid = s_axis_tvalid[grant].
//    - s_axis_tready[grant] = m_axis_tready; all other tready bits are 0.
//    - When tvalid & tready & tlast on the granted source:
//      last_grant <= grant, pkt_cnt <= pkt_cnt+1, next state is IDLE.
//  Cost of the IDLE cycle: there is exactly 1 bubble cycle between packets. The IPD stage
//    tolerates this; it is the accepted throughput cost.
//  Changes that do not cut a packet:
//    - Clearing arb_en or port_mask during XFER does not truncate the packet.
//    - The change takes effect at the next IDLE decision.
//  Granted source drops tvalid mid-packet: the grant is held; the block waits indefinitely.
//  pkt_cnt wraps from 2^C_CNT_WIDTH-1 to 0 with no saturation and no flag.
//  cur_port = grant while in XFER, last_grant while in IDLE.
//  m_axis data outputs in IDLE are don't-care; the bench checks them only when tvalid=1.
// TESTING
//  1) Reset, arb_en=1, mask=4'hF, all 4 sources each hold a 3-beat packet ->
//     grant order is 0,1,2,3; every packet completes in 3 beats plus 1 idle cycle;
//     pkt_cnt=4.
//  2) mask=4'b0101, all sources valid ->
//     only ports 0 and 2 alternate (0,2,0,2); s_axis_tready[1] and s_axis_tready[3]
//     are never 1.
//  3) m_axis_tready toggles 1,0,1,0 during a 4-beat packet from port 1 ->
//     beats are presented in order with none lost or duplicated; tlast appears only
//     on beat 4.
//  4) arb_en cleared on beat 2 of a 5-beat packet ->
//     all 5 beats are delivered, then the block stays in IDLE; pkt_cnt increments by 1.
//  5) sw_rst pulsed on beat 2 of port 2's packet ->
//     the next cycle shows m_axis_tvalid=0 and pkt_cnt=0; the next grant goes to
//     port 0 (with all sources valid).
//  6) pkt_cnt preloaded near wrap via force to 32'hFFFF_FFFF, then one packet completes ->
//     pkt_cnt=0.

Source files
------------

// File: rtl/ipd_rr_arbiter.sv
// rtl/ipd_rr_arbiter.sv - packet-granular round-robin arbiter feeding the inter-packet-delay stage
module ipd_rr_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 4,
    parameter int C_CNT_WIDTH        = 32,
    localparam int IW = $clog2(NUM_PORTS),
    localparam int SW = C_AXIS_DATA_WIDTH / 8
) (
    input  logic                                   axi_aclk,
    input  logic                                   axi_areset,
    input  logic                                   sw_rst,
    input  logic                                   arb_en,
    input  logic [NUM_PORTS-1:0]                   port_mask,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*SW-1:0]                s_axis_tstrb,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
    output logic [NUM_PORTS-1:0]                   s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [SW-1:0]                          m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]          m_axis_tuser,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tlast,
    input  logic                                   m_axis_tready,
    output logic [IW-1:0]                          cur_port,
    output logic [C_CNT_WIDTH-1:0]                 pkt_cnt
);

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    localparam logic [IW-1:0] LAST_RST = IW'(NUM_PORTS - 1);

    state_t                 state_q, state_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [IW-1:0]          last_grant_q, last_grant_d;
    logic [C_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [NUM_PORTS-1:0]   req;
    logic [IW-1:0]          pick;
    logic                   found;
    int                     idx;
    logic                   xfer;
    logic                   beat_last;

    assign req  = s_axis_tvalid & port_mask;
    assign xfer = (state_q == ST_XFER);

    // Search starts just after the last winner so every eligible source gets a turn.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_PORTS;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        m_axis_tdata  = s_axis_tdata[int'(grant_q)*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        m_axis_tstrb  = s_axis_tstrb[int'(grant_q)*SW +: SW];
        m_axis_tuser  = s_axis_tuser[int'(grant_q)*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        m_axis_tvalid = xfer & s_axis_tvalid[grant_q];
        m_axis_tlast  = xfer & s_axis_tlast[grant_q];
        s_axis_tready = '0;
        if (xfer) begin
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    assign beat_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign cur_port  = axi_areset ? '0 : (xfer ? grant_q : last_grant_q);
    assign pkt_cnt   = pkt_cnt_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pkt_cnt_d    = pkt_cnt_q;
        if (sw_rst) begin
            state_d      = ST_IDLE;
            grant_d      = '0;
            last_grant_d = LAST_RST;
            pkt_cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_en && found) begin
                        grant_d = pick;
                        state_d = ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Grant is held through tlast even if arb_en or port_mask drop.
                    if (beat_last) begin
                        last_grant_d = grant_q;
                        pkt_cnt_d    = pkt_cnt_q + 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_ipd_rr_arbiter.sv
// tb/tb_ipd_rr_arbiter.sv - scoreboard bench for ipd_rr_arbiter
module tb_ipd_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int UW = 128;

    logic              clk = 1'b0;
    logic              axi_areset;
    logic              sw_rst;
    logic              arb_en;
    logic [NP-1:0]     port_mask;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*SW-1:0]  s_tstrb;
    logic [NP*UW-1:0]  s_tuser;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [1:0]        cur_port;
    logic [31:0]       pkt_cnt;

    ipd_rr_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .NUM_PORTS         (NP),
        .C_CNT_WIDTH       (32)
    ) dut (
        .axi_aclk     (clk),
        .axi_areset   (axi_areset),
        .sw_rst       (sw_rst),
        .arb_en       (arb_en),
        .port_mask    (port_mask),
        .s_axis_tdata (s_tdata),
        .s_axis_tstrb (s_tstrb),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tstrb (m_tstrb),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready),
        .cur_port     (cur_port),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   port;
        int   seq;
        int   beat;
        logic last;
    } beat_t;

    beat_t exp_q[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    beats_seen = 0;

    // Source models: each port emits src_npk packets of src_len beats
    int    src_npk[NP];
    int    src_len[NP];
    int    src_beat[NP];
    int    src_seq[NP];
    logic [NP-1:0] hs_s = '0;
    logic [NP-1:0] rdy_acc = '0;

    function automatic logic [31:0] mkword(input int p, input int s, input int b);
        return {8'(p), 16'(s), 8'(b)};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic drive_srcs();
        logic [31:0] w;
        for (int i = 0; i < NP; i++) begin
            w = mkword(i, src_seq[i], src_beat[i]);
            s_tvalid[i]            = (src_npk[i] > 0);
            s_tlast[i]             = (src_beat[i] == src_len[i] - 1);
            s_tdata[i*DW +: DW]    = {8{w}};
            s_tstrb[i*SW +: SW]    = w;
            s_tuser[i*UW +: UW]    = {4{~w}};
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (hs_s[i]) begin
                src_beat[i]++;
                if (src_beat[i] == src_len[i]) begin
                    src_beat[i] = 0;
                    src_seq[i]++;
                    src_npk[i]--;
                end
            end
        end
        drive_srcs();
    endtask

    task automatic set_src(input int p, input int npk, input int len);
        src_npk[p]  = npk;
        src_len[p]  = len;
        src_beat[p] = 0;
    endtask

    task automatic push_pkt(input int p, input int seq, input int len);
        for (int b = 0; b < len; b++)
            exp_q.push_back('{port: p, seq: seq, beat: b, last: (b == len - 1)});
    endtask

    task automatic wait_cnt(input string name, input logic [31:0] target, input int bound);
        int n = 0;
        while (pkt_cnt != target && n < bound) begin
            step();
            n++;
        end
        chk(name, pkt_cnt, target);
    endtask

    always @(negedge clk) begin
        hs_s    = s_tvalid & s_tready;
        rdy_acc = rdy_acc | s_tready;
    end

    // Monitor: every accepted output beat must match the head of the scoreboard
    always @(negedge clk) begin
        beat_t e;
        logic [31:0] w;
        if (!axi_areset && m_tvalid && m_tready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {224'b0, m_tdata[31:0]}, 256'b0);
            end else begin
                e = exp_q.pop_front();
                w = mkword(e.port, e.seq, e.beat);
                chk("beat_tdata", m_tdata, {8{w}});
                chk("beat_tstrb", {224'b0, m_tstrb}, {224'b0, w});
                chk("beat_tuser", {128'b0, m_tuser}, {128'b0, {4{~w}}});
                chk("beat_tlast", {255'b0, m_tlast}, {255'b0, e.last});
                chk("beat_port", {254'b0, cur_port}, 256'(e.port));
            end
        end
    end

    initial begin
        int n;
        int b0;
        axi_areset = 1'b1;
        sw_rst     = 1'b0;
        arb_en     = 1'b1;
        port_mask  = 4'hF;
        m_tready   = 1'b1;
        for (int i = 0; i < NP; i++) begin
            src_seq[i] = 0;
            set_src(i, 1, 3);
        end
        drive_srcs();
        for (int i = 0; i < NP; i++) push_pkt(i, 0, 3);
        repeat (3) step();
        chk("rst_tready", {252'b0, s_tready}, 256'b0);
        chk("rst_tvalid", {255'b0, m_tvalid}, 256'b0);
        chk("rst_tlast", {255'b0, m_tlast}, 256'b0);
        chk("rst_cur_port", {254'b0, cur_port}, 256'b0);
        chk("rst_pkt_cnt", pkt_cnt, 256'b0);
        axi_areset = 1'b0;
        #1;
        chk("idle_cur_port", {254'b0, cur_port}, 256'd3);

        // Test 1: full mask, 3-beat packets, order 0,1,2,3 with one bubble each
        repeat (15) step();
        chk("t1_cnt_after15", pkt_cnt, 256'd3);
        step();
        chk("t1_cnt_after16", pkt_cnt, 256'd4);

        // Test 2: mask 0101 alternates ports 0 and 2
        port_mask = 4'b0101;
        rdy_acc   = '0;
        for (int i = 0; i < NP; i++) set_src(i, 2, 2);
        drive_srcs();
        push_pkt(0, 1, 2);
        push_pkt(2, 1, 2);
        push_pkt(0, 2, 2);
        push_pkt(2, 2, 2);
        wait_cnt("t2_cnt", 32'd8, 60);
        for (int i = 0; i < NP; i++) src_npk[i] = 0;
        drive_srcs();
        chk("t2_ready_masked", {254'b0, rdy_acc[3], rdy_acc[1]}, 256'b0);
        port_mask = 4'hF;

        // Test 3: port 1, 4 beats, downstream ready toggling
        set_src(1, 1, 4);
        drive_srcs();
        push_pkt(1, src_seq[1], 4);
        n = 0;
        while (pkt_cnt != 32'd9 && n < 40) begin
            step();
            m_tready = ~m_tready;
            n++;
        end
        chk("t3_cnt", pkt_cnt, 256'd9);
        m_tready = 1'b1;

        // Test 4: arb_en cleared during beat 2 of a 5-beat packet
        set_src(0, 1, 5);
        drive_srcs();
        push_pkt(0, src_seq[0], 5);
        b0 = beats_seen;
        n = 0;
        while (beats_seen < b0 + 1 && n < 20) begin
            step();
            n++;
        end
        arb_en = 1'b0;
        wait_cnt("t4_cnt", 32'd10, 20);
        set_src(3, 1, 2);
        drive_srcs();
        repeat (5) step();
        chk("t4_stays_idle_cnt", pkt_cnt, 256'd10);
        chk("t4_stays_idle_valid", {255'b0, m_tvalid}, 256'b0);
        chk("t4_queue_drained", 256'(exp_q.size()), 256'b0);
        arb_en = 1'b1;
        push_pkt(3, src_seq[3], 2);
        wait_cnt("t4_reenable_cnt", 32'd11, 20);

        // Test 5: sw_rst during beat 2 of port 2's packet
        set_src(2, 1, 4);
        drive_srcs();
        exp_q.push_back('{port: 2, seq: src_seq[2], beat: 0, last: 1'b0});
        exp_q.push_back('{port: 2, seq: src_seq[2], beat: 1, last: 1'b0});
        b0 = beats_seen;
        n = 0;
        while (beats_seen < b0 + 1 && n < 20) begin
            step();
            n++;
        end
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        #1;
        chk("t5_tvalid", {255'b0, m_tvalid}, 256'b0);
        chk("t5_pkt_cnt", pkt_cnt, 256'b0);
        chk("t5_cur_port", {254'b0, cur_port}, 256'd3);
        src_seq[2]++;
        for (int i = 0; i < NP; i++) begin
            set_src(i, 1, 1);
            push_pkt(i, src_seq[i], 1);
        end
        drive_srcs();
        wait_cnt("t5_cnt_after", 32'd4, 40);

        // Test 6: counter wraps to zero
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_q;
        #1;
        chk("t6_preload", pkt_cnt, 256'hFFFF_FFFF);
        set_src(1, 1, 1);
        drive_srcs();
        push_pkt(1, src_seq[1], 1);
        wait_cnt("t6_wrap", 32'd0, 20);

        repeat (3) step();
        chk("final_queue_empty", 256'(exp_q.size()), 256'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
